// File: rtl/cond_pkg.sv
// Shared definitions for the execute-side condition logic:
// ARM condition codes, NZCV bit positions and the decoder control bundle.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // Control bundle carried from decode into execute.
    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       memtoreg;
        logic       alusrc;
        logic       nowrite;
        logic       movinstr;
        logic       link;
        logic [1:0] alucontrol;
    } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation.
//   cond    : 4-bit condition field
//   flags   : current {N,Z,C,V}
//   cond_ex : 1 when the instruction should execute
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Condition table; COND_NV never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c & !z;
            COND_LS: cond_ex = !c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage control register, NZCV flag register and condition-gated enables.
//   clk, reset_n        : clock, async active-low reset
//   stall, flush        : hold / bubble the execute register (flush wins)
//   d_*                 : decoder control bundle
//   alu_flags           : {N,Z,C,V} from the execute ALU
//   e_*                 : registered controls for the execute datapath
//   cond_ex             : condition result for the instruction in execute
//   reg_write .. link_write : condition-gated write enables
//   flags               : architectural {N,Z,C,V}
//   exec_count          : instructions that passed their condition
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [3:0]       d_cond,
    input  logic [1:0]       d_flagw,
    input  logic             d_pcs,
    input  logic             d_regw,
    input  logic             d_memw,
    input  logic             d_memtoreg,
    input  logic             d_alusrc,
    input  logic             d_nowrite,
    input  logic             d_movinstr,
    input  logic             d_link,
    input  logic [1:0]       d_alucontrol,
    input  logic [3:0]       alu_flags,
    output logic             e_valid,
    output logic [1:0]       e_alucontrol,
    output logic             e_alusrc,
    output logic             e_memtoreg,
    output logic             e_movinstr,
    output logic             cond_ex,
    output logic             reg_write,
    output logic             mem_write,
    output logic             pc_src,
    output logic             link_write,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] exec_count
);

    ctrl_t d_ctrl_c;
    ctrl_t e_ctrl;
    logic  pass_c;
    logic  complete_c;

    assign d_ctrl_c = '{
        cond:       d_cond,
        flagw:      d_flagw,
        pcs:        d_pcs,
        regw:       d_regw,
        memw:       d_memw,
        memtoreg:   d_memtoreg,
        alusrc:     d_alusrc,
        nowrite:    d_nowrite,
        movinstr:   d_movinstr,
        link:       d_link,
        alucontrol: d_alucontrol
    };

    // Execute pipeline register: flush > stall > load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_valid <= 1'b0;
            e_ctrl  <= '0;
        end else if (flush) begin
            e_valid <= 1'b0;
            e_ctrl  <= '0;
        end else if (!stall) begin
            e_valid <= d_valid;
            e_ctrl  <= d_ctrl_c;
        end
    end

    cond_check u_cond_check (
        .cond    (e_ctrl.cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    assign pass_c = e_valid & cond_ex;

    // A held instruction must not retire, otherwise it would re-evaluate
    // against flags it already wrote. Flush does not cancel the instruction
    // already in execute.
    assign complete_c = pass_c & !stall;

    // Flag register and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags      <= 4'b0000;
            exec_count <= '0;
        end else if (complete_c) begin
            if (e_ctrl.flagw[1]) begin
                flags[FLAG_N] <= alu_flags[FLAG_N];
                flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (e_ctrl.flagw[0]) begin
                flags[FLAG_C] <= alu_flags[FLAG_C];
                flags[FLAG_V] <= alu_flags[FLAG_V];
            end
            exec_count <= exec_count + CNT_W'(1);
        end
    end

    assign e_alucontrol = e_ctrl.alucontrol;
    assign e_alusrc     = e_ctrl.alusrc;
    assign e_memtoreg   = e_ctrl.memtoreg;
    assign e_movinstr   = e_ctrl.movinstr;

    assign reg_write  = pass_c & e_ctrl.regw & !e_ctrl.nowrite;
    assign mem_write  = pass_c & e_ctrl.memw;
    assign pc_src     = pass_c & e_ctrl.pcs;
    assign link_write = pass_c & e_ctrl.link;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Self-checking bench for cond_exec_stage: a reference model of the stage
// compared every negative edge, plus literal expectations at key points.
module tb_cond_exec_stage;
    import cond_pkg::*;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             stall, flush, d_valid;
    logic [3:0]       d_cond;
    logic [1:0]       d_flagw;
    logic             d_pcs, d_regw, d_memw, d_memtoreg, d_alusrc;
    logic             d_nowrite, d_movinstr, d_link;
    logic [1:0]       d_alucontrol;
    logic [3:0]       alu_flags;
    logic             e_valid;
    logic [1:0]       e_alucontrol;
    logic             e_alusrc, e_memtoreg, e_movinstr;
    logic             cond_ex, reg_write, mem_write, pc_src, link_write;
    logic [3:0]       flags;
    logic [CNT_W-1:0] exec_count;

    logic [3:0]       cc_cond, cc_flags;
    logic             cc_ex;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cond_exec_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .d_valid(d_valid), .d_cond(d_cond), .d_flagw(d_flagw),
        .d_pcs(d_pcs), .d_regw(d_regw), .d_memw(d_memw),
        .d_memtoreg(d_memtoreg), .d_alusrc(d_alusrc), .d_nowrite(d_nowrite),
        .d_movinstr(d_movinstr), .d_link(d_link), .d_alucontrol(d_alucontrol),
        .alu_flags(alu_flags), .e_valid(e_valid), .e_alucontrol(e_alucontrol),
        .e_alusrc(e_alusrc), .e_memtoreg(e_memtoreg), .e_movinstr(e_movinstr),
        .cond_ex(cond_ex), .reg_write(reg_write), .mem_write(mem_write),
        .pc_src(pc_src), .link_write(link_write), .flags(flags),
        .exec_count(exec_count)
    );

    cond_check u_cc (.cond(cc_cond), .flags(cc_flags), .cond_ex(cc_ex));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ARM rule: cond[3:1] picks a base test, cond[0] inverts it; 111x is AL/never.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return (c[3:1] == 3'd7) ? !c[0] : (r ^ c[0]);
    endfunction

    // Reference model state
    logic        m_valid, m_pcs, m_regw, m_memw, m_memtoreg, m_alusrc;
    logic        m_nowrite, m_movinstr, m_link;
    logic [3:0]  m_cond, m_flags;
    logic [1:0]  m_flagw, m_alucontrol;
    logic [31:0] m_count;

    always @(posedge clk or negedge reset_n) begin : model
        if (!reset_n) begin
            m_valid <= 1'b0; m_cond <= 4'h0; m_flagw <= 2'b00; m_pcs <= 1'b0;
            m_regw <= 1'b0; m_memw <= 1'b0; m_memtoreg <= 1'b0; m_alusrc <= 1'b0;
            m_nowrite <= 1'b0; m_movinstr <= 1'b0; m_link <= 1'b0;
            m_alucontrol <= 2'b00; m_flags <= 4'h0; m_count <= 32'd0;
        end else begin
            if (m_valid && cond_model(m_cond, m_flags) && !stall) begin
                if (m_flagw[1]) m_flags[3:2] <= alu_flags[3:2];
                if (m_flagw[0]) m_flags[1:0] <= alu_flags[1:0];
                m_count <= m_count + 32'd1;
            end
            if (flush) begin
                m_valid <= 1'b0; m_cond <= 4'h0; m_flagw <= 2'b00; m_pcs <= 1'b0;
                m_regw <= 1'b0; m_memw <= 1'b0; m_memtoreg <= 1'b0; m_alusrc <= 1'b0;
                m_nowrite <= 1'b0; m_movinstr <= 1'b0; m_link <= 1'b0;
                m_alucontrol <= 2'b00;
            end else if (!stall) begin
                m_valid <= d_valid; m_cond <= d_cond; m_flagw <= d_flagw;
                m_pcs <= d_pcs; m_regw <= d_regw; m_memw <= d_memw;
                m_memtoreg <= d_memtoreg; m_alusrc <= d_alusrc;
                m_nowrite <= d_nowrite; m_movinstr <= d_movinstr; m_link <= d_link;
                m_alucontrol <= d_alucontrol;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin : compare
        logic ep;
        ep = m_valid && cond_model(m_cond, m_flags);
        chk("e_valid",      32'(e_valid),      32'(m_valid));
        chk("e_alucontrol", 32'(e_alucontrol), 32'(m_alucontrol));
        chk("e_alusrc",     32'(e_alusrc),     32'(m_alusrc));
        chk("e_memtoreg",   32'(e_memtoreg),   32'(m_memtoreg));
        chk("e_movinstr",   32'(e_movinstr),   32'(m_movinstr));
        chk("cond_ex",      32'(cond_ex),      32'(cond_model(m_cond, m_flags)));
        chk("reg_write",    32'(reg_write),    32'(ep && m_regw && !m_nowrite));
        chk("mem_write",    32'(mem_write),    32'(ep && m_memw));
        chk("pc_src",       32'(pc_src),       32'(ep && m_pcs));
        chk("link_write",   32'(link_write),   32'(ep && m_link));
        chk("flags",        32'(flags),        32'(m_flags));
        chk("exec_count",   exec_count,        m_count);
    end

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw,
                         input logic link, input logic nowr, input logic [3:0] af);
        d_valid = v; d_cond = c; d_flagw = fw; d_pcs = pcs; d_regw = regw;
        d_memw = memw; d_link = link; d_nowrite = nowr; alu_flags = af;
        d_alucontrol = c[1:0]; d_alusrc = c[0]; d_memtoreg = memw; d_movinstr = c[2];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        cc_cond = 4'h0; cc_flags = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_e_valid", 32'(e_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_count", exec_count, 32'd0);
        reset_n = 1'b1;

        // AL with full flag write
        drive(1'b1, COND_AL, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
        step();
        chk("t1_reg_write", 32'(reg_write), 32'd1);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        step();
        chk("t1_flags", 32'(flags), 32'h4);
        chk("t1_count", exec_count, 32'd1);

        // NE with Z=1 fails
        drive(1'b1, COND_NE, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100);
        step();
        chk("t2_cond_ex", 32'(cond_ex), 32'd0);
        chk("t2_pc_src", 32'(pc_src), 32'd0);
        chk("t2_reg_write", 32'(reg_write), 32'd0);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100);
        step();
        chk("t2_flags", 32'(flags), 32'h4);
        chk("t2_count", exec_count, 32'd1);

        // Three-cycle stall holds flags until the first free edge
        drive(1'b1, COND_AL, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000);
        step();
        stall = 1'b1;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_stall_flags", 32'(flags), 32'h4);
            chk("t3_stall_valid", 32'(e_valid), 32'd1);
        end
        stall = 1'b0;
        step();
        chk("t3_flags", 32'(flags), 32'h8);
        chk("t3_count", exec_count, 32'd2);

        // Flush with stall: bubble wins, held instruction does not retire
        drive(1'b1, COND_AL, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        step();
        stall = 1'b1; flush = 1'b1;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();
        chk("t4_e_valid", 32'(e_valid), 32'd0);
        chk("t4_reg_write", 32'(reg_write), 32'd0);
        chk("t4_mem_write", 32'(mem_write), 32'd0);
        chk("t4_pc_src", 32'(pc_src), 32'd0);
        chk("t4_link_write", 32'(link_write), 32'd0);
        chk("t4_count", exec_count, 32'd2);
        stall = 1'b0; flush = 1'b0;

        // Flush alone: instruction in execute still completes, CV-only write
        drive(1'b1, COND_AL, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011);
        step();
        flush = 1'b1;
        drive(1'b1, COND_AL, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011);
        step();
        flush = 1'b0;
        chk("t5_e_valid", 32'(e_valid), 32'd0);
        chk("t5_count", exec_count, 32'd3);
        chk("t5_flags", 32'(flags), 32'hB);

        // Back-to-back: EQ sees flags from the previous AL, no bypass
        drive(1'b1, COND_AL, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);
        step();
        drive(1'b1, COND_EQ, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);
        step();
        alu_flags = 4'b0000;
        #1;
        chk("t6_flags", 32'(flags), 32'h6);
        chk("t6_eq_cond_ex", 32'(cond_ex), 32'd1);
        drive(1'b1, COND_NE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
        step();
        chk("t6_ne_cond_ex", 32'(cond_ex), 32'd0);
        chk("t6_count", exec_count, 32'd5);

        // nowrite suppresses reg_write
        drive(1'b1, COND_AL, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
        step();
        chk("t7_nowrite", 32'(reg_write), 32'd0);

        // Sweep every condition code through the pipe
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'(i), 2'b11, i[0], 1'b1, i[1], i[2], 1'b0, 4'(i * 7));
            step();
        end
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step();

        // Exhaustive condition table
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                cc_cond = 4'(c); cc_flags = 4'(f);
                #1;
                chk("cond_table", 32'(cc_ex), 32'(cond_model(4'(c), 4'(f))));
            end
        end
        cc_cond = COND_GE; cc_flags = 4'b1001; #1;
        chk("spot_ge_1001", 32'(cc_ex), 32'd1);
        cc_cond = COND_LE; cc_flags = 4'b1000; #1;
        chk("spot_le_1000", 32'(cc_ex), 32'd1);
        cc_cond = COND_NV; cc_flags = 4'b0000; #1;
        chk("spot_nv", 32'(cc_ex), 32'd0);

        // Asynchronous reset mid-instruction
        drive(1'b1, COND_AL, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111);
        step();
        drive(1'b1, COND_AL, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1111);
        step();
        chk("t8_pre_flags", 32'(flags), 32'hF);
        chk("t8_pre_valid", 32'(e_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t8_flags", 32'(flags), 32'd0);
        chk("t8_e_valid", 32'(e_valid), 32'd0);
        chk("t8_reg_write", 32'(reg_write), 32'd0);
        chk("t8_mem_write", 32'(mem_write), 32'd0);
        chk("t8_count", exec_count, 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
Name: cond_exec_stage

Overview:
- Execute-side stage directly downstream of the instruction decoder.
- Registers the decoder's control bundle into the execute stage (one pipeline register, with stall and flush) and holds the architectural NZCV flag register.
- Evaluates the 4-bit ARM condition field against the flags.
- Produces the condition-gated write enables: RegWrite, MemWrite, PCSrc and link write. It also updates the flags from the ALU according to FlagW.

Parameters:
- CNT_W, 32, width of the executed-instruction counter exec_count.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hold the execute register and flags
- flush  in  1  load a bubble into the execute register
- d_valid  in  1  decode-stage bundle is a real instruction
- d_cond  in  4  instruction condition field [31:28]
- d_flagw  in  2  flag write: [1] updates N,Z; [0] updates C,V
- d_pcs, d_regw, d_memw, d_memtoreg, d_alusrc, d_nowrite, d_movinstr, d_link  in  1 each  decoder controls
- d_alucontrol  in  2  ALU operation
- alu_flags  in  4  {N,Z,C,V} from the execute-stage ALU, same cycle
- e_valid  out  1  execute register holds an instruction
- e_alucontrol  out  2; e_alusrc, e_memtoreg, e_movinstr  out  1 each  registered controls
- cond_ex  out  1  condition passed for the instruction in execute
- reg_write, mem_write, pc_src, link_write  out  1 each  gated enables
- flags  out  4  current {N,Z,C,V}
- exec_count  out  CNT_W  count of instructions that passed their condition

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All execute registers cleared; e_valid=0; flags=4'b0000; exec_count=0.
  - All gated outputs are therefore 0.
- Execute register update, priority at each rising edge: flush > stall > load.
  - flush=1: e_valid<=0 and all e_* controls <=0. Flush wins over a simultaneous stall.
  - stall=1, flush=0: the register holds.
  - Otherwise: all d_* are captured; e_valid<=d_valid.
  - Latency from d_* to e_* is one cycle.
- Condition check is combinational on the registered e_cond and the current flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; 4'b1111 gives 0 (never executes).
- Gated outputs (combinational):
  - reg_write = e_valid & cond_ex & e_regw & !e_nowrite
  - mem_write = e_valid & cond_ex & e_memw
  - pc_src = e_valid & cond_ex & e_pcs
  - link_write = e_valid & cond_ex & e_link
- Flag update at each edge when e_valid & cond_ex & !stall:
  - e_flagw[1]: flags[3:2] <= alu_flags[3:2].
  - e_flagw[0]: flags[1:0] <= alu_flags[1:0].
  - During a stall the flags must not change, so a held instruction re-evaluates its condition against the same flags.
  - A flush in the same cycle does not suppress the update; the instruction in execute completes.
- exec_count increments by 1 under the same condition as the flag update (e_valid & cond_ex & !stall), independent of FlagW. It wraps modulo 2^CNT_W.
- Back-to-back flag use: the instruction in execute sees the flags written by the previous instruction, with no bypass from the current alu_flags.
- Reset mid-stall or mid-flush: reset dominates immediately; no pending update survives.

Decomposition:
- Shared package cond_pkg:
  - the 16 condition-code localparams (COND_EQ … COND_AL, COND_NV=4'hF);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, cond_check: purely combinational, (cond[3:0], flags[3:0]) -> cond_ex.
- The top level holds the execute register, the flag register and the counter.

Test Plan:
- Reset, then load d_valid=1, d_cond=AL (4'hE), d_regw=1, d_flagw=2'b11, alu_flags=4'b0100 -> next cycle reg_write=1; following edge flags=4'b0100; exec_count=1.
- With flags Z=1, load d_cond=NE (4'h1), d_pcs=1, d_regw=1 -> cond_ex=0, pc_src=0, reg_write=0; flags and exec_count unchanged.
- Hold stall=1 for 3 cycles with an AL, flagw=2'b11 instruction in execute and alu_flags=4'b1000 -> flags unchanged through the stall, updated to 4'b1000 only on the first non-stall edge; exec_count increments once.
- Assert flush=1 together with stall=1 -> e_valid=0 next cycle; all gated outputs 0.
- Check all 16 cond codes across all 16 NZCV values via cond_check -> matches the table, with 4'hF always 0. Spot checks: GE passes at flags 4'b1001; LE passes at 4'b1000.
- Assert reset_n=0 mid-instruction with e_valid=1 and flags=4'b1111 -> all outputs 0 and flags=0 immediately, without waiting for a clock edge.
